// File: rtl/freelist_pkg.sv
// Rename-stage shared definitions: register-file geometry, free-list FSM encoding
// and wrap-pointer helpers shared with the rob and the RAT.
package rename_pkg;
  localparam int PREG_NUM   = 64;
  localparam int PREG_WIDTH = 6;
  localparam int ARCH_NUM   = 32;
  localparam int PTR_WIDTH  = $clog2(PREG_NUM) + 1;

  typedef enum logic {
    FL_IDLE    = 1'b0,
    FL_RECOVER = 1'b1
  } fl_state_e;

  function automatic logic [PREG_WIDTH-1:0] ptr_idx(input logic [PTR_WIDTH-1:0] ptr);
    return ptr[PREG_WIDTH-1:0];
  endfunction

  // The wrap bit falls out of the natural 7-bit overflow.
  function automatic logic [PTR_WIDTH-1:0] ptr_add(input logic [PTR_WIDTH-1:0] ptr,
                                                   input logic [1:0] inc);
    return ptr + PTR_WIDTH'(inc);
  endfunction
endpackage

// File: rtl/freelist_if.sv
// Free-list bundle: rename allocation, rob commit release and rob walk recovery.
interface freelist_if;
  import rename_pkg::*;

  logic                  alloc_en0, alloc_en1;
  logic [PREG_WIDTH-1:0] alloc_prd0, alloc_prd1;
  logic                  alloc_ready0, alloc_ready1;
  logic [PTR_WIDTH-1:0]  free_cnt;
  logic                  commit_valid0, commit_need_to_wb;
  logic [PREG_WIDTH-1:0] commit_old_prd;
  logic                  is_rollingback, is_walking;
  logic                  walking_valid0, walking_valid1;
  logic [PREG_WIDTH-1:0] walking_prd0, walking_prd1;
  logic                  busy, walk_mismatch;

  modport master (
    output alloc_en0, alloc_en1, commit_valid0, commit_need_to_wb, commit_old_prd,
           is_rollingback, is_walking, walking_valid0, walking_valid1,
           walking_prd0, walking_prd1,
    input  alloc_prd0, alloc_prd1, alloc_ready0, alloc_ready1, free_cnt,
           busy, walk_mismatch
  );

  modport slave (
    input  alloc_en0, alloc_en1, commit_valid0, commit_need_to_wb, commit_old_prd,
           is_rollingback, is_walking, walking_valid0, walking_valid1,
           walking_prd0, walking_prd1,
    output alloc_prd0, alloc_prd1, alloc_ready0, alloc_ready1, free_cnt,
           busy, walk_mismatch
  );
endinterface

// File: rtl/freelist_ptr.sv
// Wrap-bit queue pointer: advance by 0/1/2 per cycle, or load an absolute value.
module freelist_ptr
  import rename_pkg::*;
#(
  parameter logic [PTR_WIDTH-1:0] RST_VAL = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           inc_i,
  input  logic                 load_i,
  input  logic [PTR_WIDTH-1:0] load_val_i,
  output logic [PTR_WIDTH-1:0] ptr_o
);
  logic [PTR_WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_add(ptr_q, inc_i);
    if (load_i) ptr_d = load_val_i;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= RST_VAL;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/freelist.sv
// Physical-register free list: circular queue with speculative/commit heads and a
// release tail; rollback snaps the spec head back and the rob walk re-pops survivors.
module freelist
  import rename_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  freelist_if.slave fl
);
  fl_state_e             state_q, state_d;
  logic [PREG_WIDTH-1:0] queue_q [PREG_NUM];
  logic [PREG_WIDTH-1:0] queue_d [PREG_NUM];
  logic                  walk_mismatch_q, walk_mismatch_d;
  logic [PTR_WIDTH-1:0]  spec_head, commit_head, tail, free_cnt;
  logic                  idle, commit_fire, overflow, push;
  logic                  alloc0, alloc1, walk_act, pop0, pop1, walk_err;
  logic [1:0]            spec_inc;
  logic [PTR_WIDTH-1:0]  spec_load_val;

  assign idle        = (state_q == FL_IDLE);
  assign free_cnt    = tail - spec_head;
  assign commit_fire = fl.commit_valid0 && fl.commit_need_to_wb;
  assign overflow    = ((tail - commit_head) == PTR_WIDTH'(PREG_NUM));
  assign push        = commit_fire && !overflow;

  assign fl.alloc_prd0    = queue_q[ptr_idx(spec_head)];
  assign fl.alloc_prd1    = queue_q[ptr_idx(ptr_add(spec_head, 2'd1))];
  assign fl.alloc_ready0  = idle && (free_cnt != '0);
  assign fl.alloc_ready1  = idle && (free_cnt >= PTR_WIDTH'(2));
  assign fl.free_cnt      = free_cnt;
  assign fl.busy          = !idle;
  assign fl.walk_mismatch = walk_mismatch_q;

  // Rollback and walk own the spec head; allocation only gets it on quiet cycles.
  assign walk_act = fl.is_walking && !fl.is_rollingback;
  assign alloc0   = fl.alloc_en0 && fl.alloc_ready0 && !fl.is_rollingback && !fl.is_walking;
  assign alloc1   = alloc0 && fl.alloc_en1 && fl.alloc_ready1;

  // A blocked pop (nothing left between spec head and tail) never moves the head.
  always_comb begin
    pop0     = walk_act && fl.walking_valid0 && (free_cnt != '0);
    pop1     = walk_act && fl.walking_valid1 && ((free_cnt - PTR_WIDTH'(pop0)) != '0);
    walk_err = 1'b0;
    if (walk_act && fl.walking_valid0 && !pop0) walk_err = 1'b1;
    if (walk_act && fl.walking_valid1 && !pop1) walk_err = 1'b1;
    if (pop0 && queue_q[ptr_idx(spec_head)] != fl.walking_prd0) walk_err = 1'b1;
    if (pop1 && queue_q[ptr_idx(ptr_add(spec_head, {1'b0, pop0}))] != fl.walking_prd1)
      walk_err = 1'b1;
  end

  always_comb begin
    spec_inc      = walk_act ? ({1'b0, pop0} + {1'b0, pop1})
                             : ({1'b0, alloc0} + {1'b0, alloc1});
    spec_load_val = ptr_add(commit_head, {1'b0, push});
  end

  always_comb begin
    queue_d = queue_q;
    if (push) queue_d[ptr_idx(tail)] = fl.commit_old_prd;
    walk_mismatch_d = walk_mismatch_q || walk_err || (commit_fire && overflow);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FL_IDLE:    if (fl.is_rollingback) state_d = FL_RECOVER;
      FL_RECOVER: if (!fl.is_walking && !fl.is_rollingback) state_d = FL_IDLE;
      default:    state_d = FL_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= FL_IDLE;
      walk_mismatch_q <= 1'b0;
      for (int i = 0; i < PREG_NUM; i++)
        queue_q[i] <= (i < PREG_NUM - ARCH_NUM) ? PREG_WIDTH'(ARCH_NUM + i) : '0;
    end else begin
      state_q         <= state_d;
      walk_mismatch_q <= walk_mismatch_d;
      queue_q         <= queue_d;
    end
  end

  freelist_ptr #(.RST_VAL('0)) u_spec (
    .clock(clock), .reset(reset), .inc_i(spec_inc),
    .load_i(fl.is_rollingback), .load_val_i(spec_load_val), .ptr_o(spec_head)
  );

  freelist_ptr #(.RST_VAL('0)) u_commit (
    .clock(clock), .reset(reset), .inc_i({1'b0, push}),
    .load_i(1'b0), .load_val_i('0), .ptr_o(commit_head)
  );

  freelist_ptr #(.RST_VAL(PTR_WIDTH'(PREG_NUM - ARCH_NUM))) u_tail (
    .clock(clock), .reset(reset), .inc_i({1'b0, push}),
    .load_i(1'b0), .load_val_i('0), .ptr_o(tail)
  );
endmodule

// File: tb/tb_freelist.sv
// Free-list bench: directed rename/commit/rollback scenarios followed by random
// traffic, every cycle compared against an unbounded-counter queue model.
module tb_freelist;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  freelist_if fif ();
  freelist dut (.clock(clock), .reset(reset), .fl(fif.slave));

  int n_chk  = 0;
  int n_pass = 0;

  // Reference: plain integer heads that never wrap, array indexed modulo 64.
  int m_q [64];
  int m_spec, m_cmt, m_tail;
  bit m_rec, m_mis;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clr_inputs();
    fif.alloc_en0 = 0; fif.alloc_en1 = 0;
    fif.commit_valid0 = 0; fif.commit_need_to_wb = 0; fif.commit_old_prd = '0;
    fif.is_rollingback = 0; fif.is_walking = 0;
    fif.walking_valid0 = 0; fif.walking_valid1 = 0;
    fif.walking_prd0 = '0; fif.walking_prd1 = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_q[i] = (i < 32) ? 32 + i : 0;
    m_spec = 0; m_cmt = 0; m_tail = 32; m_rec = 0; m_mis = 0;
  endtask

  task automatic check_outputs();
    int free;
    free = m_tail - m_spec;
    chk("alloc_prd0", fif.alloc_prd0, m_q[m_spec % 64]);
    chk("alloc_prd1", fif.alloc_prd1, m_q[(m_spec + 1) % 64]);
    chk("free_cnt", fif.free_cnt, free);
    chk("ready0", fif.alloc_ready0, (!m_rec && free >= 1) ? 1 : 0);
    chk("ready1", fif.alloc_ready1, (!m_rec && free >= 2) ? 1 : 0);
    chk("busy", fif.busy, m_rec);
    chk("walk_mismatch", fif.walk_mismatch, m_mis);
  endtask

  task automatic model_step();
    int free, nspec, pos, av;
    bit fire, ovf;
    free  = m_tail - m_spec;
    fire  = fif.commit_valid0 && fif.commit_need_to_wb;
    ovf   = (m_tail - m_cmt) == 64;
    nspec = m_spec;
    if (fif.is_rollingback) begin
      nspec = m_cmt + ((fire && !ovf) ? 1 : 0);
    end else if (fif.is_walking) begin
      pos = m_spec; av = free;
      if (fif.walking_valid0) begin
        if (av == 0) m_mis = 1;
        else begin
          if (m_q[pos % 64] != int'(fif.walking_prd0)) m_mis = 1;
          pos++; av--;
        end
      end
      if (fif.walking_valid1) begin
        if (av == 0) m_mis = 1;
        else begin
          if (m_q[pos % 64] != int'(fif.walking_prd1)) m_mis = 1;
          pos++;
        end
      end
      nspec = pos;
    end else if (!m_rec && fif.alloc_en0 && free >= 1) begin
      nspec = m_spec + ((fif.alloc_en1 && free >= 2) ? 2 : 1);
    end
    if (fire) begin
      if (ovf) m_mis = 1;
      else begin
        m_q[m_tail % 64] = fif.commit_old_prd;
        m_tail++; m_cmt++;
      end
    end
    if (!m_rec) m_rec = fif.is_rollingback;
    else if (!fif.is_walking && !fif.is_rollingback) m_rec = 0;
    m_spec = nspec;
  endtask

  // Inputs are set before the call; outputs sampled on the falling edge.
  task automatic cycle();
    @(negedge clock);
    check_outputs();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    clr_inputs();
    model_reset();
    #1 check_outputs();
    @(negedge clock) reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic commit(input int old);
    fif.commit_valid0 = 1; fif.commit_need_to_wb = 1; fif.commit_old_prd = 6'(old);
  endtask

  task automatic rollback_walk(input int p0, input int p1);
    clr_inputs(); fif.is_rollingback = 1; cycle();
    clr_inputs(); fif.is_walking = 1;
    fif.walking_valid0 = 1; fif.walking_valid1 = 1;
    fif.walking_prd0 = 6'(p0); fif.walking_prd1 = 6'(p1); cycle();
    clr_inputs(); cycle();
  endtask

  initial begin
    int r, beats, lim;
    bit v0, v1;
    clr_inputs();
    model_reset();
    #12;
    do_reset();
    // Scenario 1: reset values, drain by dual allocs, then starved alloc
    chk("rst_prd0", fif.alloc_prd0, 32);
    chk("rst_prd1", fif.alloc_prd1, 33);
    chk("rst_free", fif.free_cnt, 32);
    chk("rst_busy", fif.busy, 0);
    for (int i = 0; i < 16; i++) begin
      clr_inputs(); fif.alloc_en0 = 1; fif.alloc_en1 = 1; cycle();
    end
    chk("s1_free", fif.free_cnt, 0);
    chk("s1_ready0", fif.alloc_ready0, 0);
    clr_inputs(); fif.alloc_en0 = 1; cycle();
    chk("s1_hold_free", fif.free_cnt, 0);
    // Scenario 2: two allocs, two releases
    do_reset();
    clr_inputs(); fif.alloc_en0 = 1; fif.alloc_en1 = 1; cycle();
    clr_inputs(); commit(5); cycle();
    clr_inputs(); commit(7); cycle();
    clr_inputs(); cycle();
    chk("s2_free", fif.free_cnt, 32);
    // Scenario 3: rollback with two correct survivors
    do_reset();
    for (int i = 0; i < 3; i++) begin
      clr_inputs(); fif.alloc_en0 = 1; fif.alloc_en1 = 1; cycle();
    end
    clr_inputs(); commit(3); cycle();
    rollback_walk(33, 34);
    chk("s3_free", fif.free_cnt, 30);
    chk("s3_mis", fif.walk_mismatch, 0);
    chk("s3_prd0", fif.alloc_prd0, 35);
    // Scenario 4: same, wrong survivor prd -> sticky mismatch
    do_reset();
    for (int i = 0; i < 3; i++) begin
      clr_inputs(); fif.alloc_en0 = 1; fif.alloc_en1 = 1; cycle();
    end
    clr_inputs(); commit(3); cycle();
    rollback_walk(40, 34);
    chk("s4_mis", fif.walk_mismatch, 1);
    for (int i = 0; i < 4; i++) begin
      clr_inputs(); fif.alloc_en0 = 1; cycle();
    end
    chk("s4_sticky", fif.walk_mismatch, 1);
    // Scenario 5: rollback coincides with a release; alloc that cycle is dropped
    do_reset();
    clr_inputs(); fif.alloc_en0 = 1; fif.alloc_en1 = 1; cycle();
    clr_inputs(); fif.is_rollingback = 1; fif.alloc_en0 = 1; commit(11); cycle();
    chk("s5_busy", fif.busy, 1);
    chk("s5_prd0", fif.alloc_prd0, 33);
    chk("s5_free", fif.free_cnt, 32);
    clr_inputs(); cycle();
    // Scenario 6: pointer wrap with steady alloc/release
    do_reset();
    clr_inputs(); fif.alloc_en0 = 1; cycle();
    for (int k = 0; k < 80; k++) begin
      clr_inputs(); fif.alloc_en0 = 1; commit((k * 7 + 1) % 64); cycle();
    end
    clr_inputs(); commit(63); cycle();
    chk("s6_free", fif.free_cnt, 32);
    // Random traffic
    do_reset();
    beats = 0; lim = 0;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 199);
      clr_inputs();
      if (r == 0) begin
        do_reset();
        beats = 0;
        continue;
      end
      if (m_cmt < m_spec && $urandom_range(0, 1) == 1) begin
        fif.commit_valid0 = 1;
        fif.commit_need_to_wb = ($urandom_range(0, 4) != 0);
        fif.commit_old_prd = 6'($urandom_range(0, 63));
      end
      if (!m_rec) begin
        if (r < 8) begin
          fif.is_rollingback = 1;
          lim = m_spec;
          beats = $urandom_range(0, 3);
        end else begin
          fif.alloc_en0 = ($urandom_range(0, 9) < 6);
          fif.alloc_en1 = fif.alloc_en0 && $urandom_range(0, 1);
        end
      end else if (beats > 0) begin
        beats--;
        fif.is_walking = 1;
        v0 = (m_spec < lim) && $urandom_range(0, 3) != 0;
        v1 = (m_spec + v0 < lim) && $urandom_range(0, 1);
        fif.walking_valid0 = v0;
        fif.walking_valid1 = v1;
        fif.walking_prd0 = 6'(m_q[m_spec % 64]);
        fif.walking_prd1 = 6'(m_q[(m_spec + v0) % 64]);
        if ($urandom_range(0, 49) == 0) fif.walking_prd0 = fif.walking_prd0 ^ 6'd1;
        if (fif.commit_valid0 && m_cmt >= m_spec) fif.commit_valid0 = 0;
      end
      cycle();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
